// File: rtl/b_registered_input_to_output_new_primitive.sv
// b_registered_input_to_output_new_primitive: two-stage registered 20x18 unsigned multiplier
module b_registered_input_to_output_new_primitive (
  input  logic [19:0] a,
  input  logic [17:0] b,
  input  logic        clk,
  input  logic        reset,
  output logic [17:0] dly_b,
  output logic [37:0] z_out
);
  logic [19:0] a_r;
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r   <= '0;
      dly_b <= '0;
      z_out <= '0;
    end else begin
      a_r   <= a;
      dly_b <= b;
      z_out <= 38'(a_r) * 38'(dly_b);
    end
  end
endmodule

// File: tb/tb_b_registered_input_to_output_new_primitive.sv
// tb_b_registered_input_to_output_new_primitive: scoreboard bench for the registered multiplier
module tb_b_registered_input_to_output_new_primitive;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] a = '0;
  logic [17:0] b = '0;
  logic [17:0] dly_b;
  logic [37:0] z_out;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [37:0] z;
    logic [17:0] d;
    string       nm;
  } exp_t;
  exp_t sbq[$];

  logic [19:0] pa = '0;
  logic [17:0] pb = '0;
  logic        prst = 1'b1;

  b_registered_input_to_output_new_primitive dut (
    .a(a), .b(b), .clk(clk), .reset(reset), .dly_b(dly_b), .z_out(z_out)
  );

  always #5 clk = ~clk;

  // Expected z_out after an edge comes from the inputs one edge earlier, unless either edge was in reset.
  task automatic step(input logic [19:0] na, input logic [17:0] nb, input logic rst,
                      input string nm, input bit hand = 1'b0, input logic [37:0] hz = '0);
    exp_t e;
    @(negedge clk);
    a = na;
    b = nb;
    reset = rst;
    e.d  = rst ? 18'd0 : nb;
    e.z  = rst ? 38'd0 : hand ? hz : prst ? 38'd0 : 38'(pa) * 38'(pb);
    e.nm = nm;
    sbq.push_back(e);
    pa = na;
    pb = nb;
    prst = rst;
  endtask

  task automatic held(input logic [19:0] na, input logic [17:0] nb, input string nm,
                      input logic [37:0] hz);
    step(na, nb, 1'b0, nm);
    step(na, nb, 1'b0, nm, 1'b1, hz);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        checks += 2;
        if (z_out !== e.z) begin
          errors++;
          $display("FAIL %s z_out got %h want %h", e.nm, z_out, e.z);
        end
        if (dly_b !== e.d) begin
          errors++;
          $display("FAIL %s dly_b got %h want %h", e.nm, dly_b, e.d);
        end
      end
    end
  end

  initial begin : stim
    logic [19:0] ra;
    logic [17:0] rb;
    step(20'd0, 18'd0, 1'b1, "reset");
    step(20'd0, 18'd0, 1'b1, "reset");
    step(20'h7FFFF, 18'h1FFFF, 1'b0, "release");
    step(20'h7FFFF, 18'h1FFFF, 1'b0, "directed", 1'b1, 38'hF_FFF6_0001);
    held(20'hFFFFF, 18'h3FFFF, "max", 38'h3F_FFEC_0001);
    held(20'd3, 18'd5, "small", 38'd15);
    held(20'd1000, 18'd1000, "dec", 38'd1000000);
    held(20'h12345, 18'h00001, "unit_b", 38'h12345);
    held(20'd0, 18'h3FFFF, "zero_a", 38'd0);
    held(20'hFFFFF, 18'd0, "zero_b", 38'd0);
    held(20'h80000, 18'h20000, "msb", 38'h10_0000_0000);
    for (int i = 0; i < 600; i++) begin
      ra = 20'($urandom);
      rb = 18'($urandom);
      step(ra, rb, 1'b0, "rand_hold");
      step(ra, rb, 1'b0, "rand_hold");
    end
    for (int i = 0; i < 60; i++) begin
      ra = 20'($urandom);
      rb = 18'($urandom);
      step(ra, rb, (i == 30), (i == 30) ? "mid_reset" : "pipe");
    end
    step(20'hFFFFF, 18'h3FFFF, 1'b1, "tail_reset");
    step(20'hFFFFF, 18'h3FFFF, 1'b0, "tail_release", 1'b1, 38'd0);
    step(20'h00002, 18'h00003, 1'b0, "tail_resume", 1'b1, 38'h3F_FFEC_0001);
    step(20'h00002, 18'h00003, 1'b0, "tail_next", 1'b1, 38'd6);
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
